// File: rtl/lcd_write_driver_if.sv
// ============================================================================
// lcd_write_driver_if : write-request handshake between requester and engine
// Rev 1.0
// ============================================================================
`default_nettype none

interface lcd_write_driver_if;
  logic       i_wr_vld;
  logic       i_wr_rs;
  logic [7:0] i_wr_data;
  logic       o_wr_rdy;
  logic       o_busy;

  modport master (
    output i_wr_vld, i_wr_rs, i_wr_data,
    input  o_wr_rdy, o_busy
  );

  modport slave (
    input  i_wr_vld, i_wr_rs, i_wr_data,
    output o_wr_rdy, o_busy
  );
endinterface

`default_nettype wire

// File: rtl/lcd_write_driver.sv
// ============================================================================
// lcd_write_driver : HD44780 write engine (setup / EN pulse / hold / exec wait)
// Optional macro LCD_INIT_EN: power-on 0x38,0x0C,0x01,0x06 init sequence.
// Rev 1.0
// ============================================================================
`default_nettype none

module lcd_write_driver #(
  parameter int T_SETUP_CYC = 2,
  parameter int T_EN_CYC    = 12,
  parameter int T_HOLD_CYC  = 2,
  parameter int T_EXEC_CYC  = 2000,
  parameter int T_CLR_CYC   = 80000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  lcd_write_driver_if.slave bus,
  output logic [7:0]        o_lcd_data,
  output logic              o_lcd_rs,
  output logic              o_lcd_rw,
  output logic              o_lcd_en,
  output logic              o_lcd_on
);

  localparam int C_MAX_A = (T_SETUP_CYC > T_EN_CYC) ? T_SETUP_CYC : T_EN_CYC;
  localparam int C_MAX_B = (T_HOLD_CYC > T_EXEC_CYC) ? T_HOLD_CYC : T_EXEC_CYC;
  localparam int C_MAX_C = (C_MAX_A > C_MAX_B) ? C_MAX_A : C_MAX_B;
  localparam int C_MAX   = (C_MAX_C > T_CLR_CYC) ? C_MAX_C : T_CLR_CYC;
  localparam int C_CW    = $clog2(C_MAX) + 1;

  localparam logic [C_CW-1:0] C_ONE      = C_CW'(1);
  localparam logic [C_CW-1:0] C_SETUP_LD = C_CW'(T_SETUP_CYC - 1);
  localparam logic [C_CW-1:0] C_EN_LD    = C_CW'(T_EN_CYC - 1);
  localparam logic [C_CW-1:0] C_HOLD_LD  = C_CW'(T_HOLD_CYC - 1);
  localparam logic [C_CW-1:0] C_EXEC_LD  = C_CW'(T_EXEC_CYC - 1);
  localparam logic [C_CW-1:0] C_CLR_LD   = C_CW'(T_CLR_CYC - 1);

`ifdef LCD_INIT_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_HOLD  = 3'd3,
    S_WAIT  = 3'd4,
    S_INIT  = 3'd5
  } state_t;
  localparam state_t C_RST_STATE = S_INIT;
  localparam logic   C_RST_RDY   = 1'b0;

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    init_byte = 8'h38;
      2'd1:    init_byte = 8'h0C;
      2'd2:    init_byte = 8'h01;
      default: init_byte = 8'h06;
    endcase
  endfunction
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_HOLD  = 3'd3,
    S_WAIT  = 3'd4
  } state_t;
  localparam state_t C_RST_STATE = S_IDLE;
  localparam logic   C_RST_RDY   = 1'b1;
`endif

  state_t          r_state;
  logic [C_CW-1:0] r_cnt;
  logic            r_long;
  logic            r_rdy;
  logic [7:0]      r_lcd_data;
  logic            r_lcd_rs;
  logic            r_lcd_en;
  logic            r_lcd_on;
`ifdef LCD_INIT_EN
  logic [2:0]      r_init_cnt;
`endif

  logic            w_load;
  logic            w_ld_rs;
  logic [7:0]      w_ld_data;
  logic            w_ld_long;
  logic            w_more_init;
  logic            w_cnt_zero;

  // Source of the next byte: init table while it still has entries, else requester.
  always_comb begin
    w_ld_rs     = bus.i_wr_rs;
    w_ld_data   = bus.i_wr_data;
    w_more_init = 1'b0;
`ifdef LCD_INIT_EN
    w_more_init = (r_init_cnt != 3'd4);
    if (w_more_init) begin
      w_ld_rs   = 1'b0;
      w_ld_data = init_byte(r_init_cnt[1:0]);
    end
`endif
    w_ld_long  = !w_ld_rs && (w_ld_data[7:2] == 6'd0) && (w_ld_data[1:0] != 2'd0);
    w_cnt_zero = (r_cnt == '0);
    case (r_state)
      S_IDLE:  w_load = bus.i_wr_vld;
      // init bytes chain straight from one WAIT into the next SETUP
      S_WAIT:  w_load = w_cnt_zero && w_more_init;
`ifdef LCD_INIT_EN
      S_INIT:  w_load = 1'b1;
`endif
      default: w_load = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= C_RST_STATE;
      r_cnt      <= '0;
      r_long     <= 1'b0;
      r_rdy      <= C_RST_RDY;
      r_lcd_data <= 8'h00;
      r_lcd_rs   <= 1'b0;
      r_lcd_en   <= 1'b0;
      r_lcd_on   <= 1'b0;
`ifdef LCD_INIT_EN
      r_init_cnt <= 3'd0;
`endif
    end else begin
      r_lcd_on <= 1'b1;
      if (w_load) begin
        r_state    <= S_SETUP;
        r_cnt      <= C_SETUP_LD;
        r_lcd_rs   <= w_ld_rs;
        r_lcd_data <= w_ld_data;
        r_long     <= w_ld_long;
        r_rdy      <= 1'b0;
`ifdef LCD_INIT_EN
        if (w_more_init) r_init_cnt <= r_init_cnt + 3'd1;
`endif
      end else begin
        case (r_state)
          S_IDLE: ;
          S_SETUP: begin
            if (w_cnt_zero) begin
              r_state  <= S_PULSE;
              r_cnt    <= C_EN_LD;
              r_lcd_en <= 1'b1;
            end else begin
              r_cnt <= r_cnt - C_ONE;
            end
          end
          S_PULSE: begin
            if (w_cnt_zero) begin
              r_state  <= S_HOLD;
              r_cnt    <= C_HOLD_LD;
              r_lcd_en <= 1'b0;
            end else begin
              r_cnt <= r_cnt - C_ONE;
            end
          end
          S_HOLD: begin
            if (w_cnt_zero) begin
              r_state <= S_WAIT;
              r_cnt   <= r_long ? C_CLR_LD : C_EXEC_LD;
            end else begin
              r_cnt <= r_cnt - C_ONE;
            end
          end
          S_WAIT: begin
            if (w_cnt_zero) begin
              r_state <= S_IDLE;
              r_rdy   <= 1'b1;
            end else begin
              r_cnt <= r_cnt - C_ONE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.o_wr_rdy = r_rdy;
  assign bus.o_busy   = ~r_rdy;
  assign o_lcd_data   = r_lcd_data;
  assign o_lcd_rs     = r_lcd_rs;
  assign o_lcd_rw     = 1'b0;
  assign o_lcd_en     = r_lcd_en;
  assign o_lcd_on     = r_lcd_on;

endmodule

`default_nettype wire

// File: tb/tb_lcd_write_driver.sv
// ============================================================================
// tb_lcd_write_driver : vector table, corner sequences and random writes vs model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_lcd_write_driver;
  localparam int S = 2;
  localparam int E = 4;
  localparam int H = 2;
  localparam int X = 10;
  localparam int C = 40;
`ifdef LCD_INIT_EN
  localparam int INIT_N = 4;
`else
  localparam int INIT_N = 0;
`endif
  localparam logic [7:0] INIT_TBL [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en, lcd_on;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic [7:0] pulses [$];
  logic [7:0] exp_q [$];

  lcd_write_driver_if bus();

  lcd_write_driver #(
    .T_SETUP_CYC (S),
    .T_EN_CYC    (E),
    .T_HOLD_CYC  (H),
    .T_EXEC_CYC  (X),
    .T_CLR_CYC   (C)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .bus        (bus.slave),
    .o_lcd_data (lcd_data),
    .o_lcd_rs   (lcd_rs),
    .o_lcd_rw   (lcd_rw),
    .o_lcd_en   (lcd_en),
    .o_lcd_on   (lcd_on)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int xfer_len(input logic rs, input logic [7:0] d);
    return S + E + H + ((!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? C : X);
  endfunction

  // Reference model: each transfer is an accept edge plus a total length in cycles.
  bit         m_active;
  int         m_acc, m_len, m_init_left;
  logic [7:0] m_byte;
  logic       m_rs, m_on;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_active = 0; m_acc = 0; m_len = 0; m_byte = 8'h00; m_rs = 1'b0; m_on = 1'b0;
        m_init_left = INIT_N;
      end else begin
        m_on = 1'b1;
        if (m_init_left > 0 && (!m_active || cyc - m_acc == m_len - 1)) begin
          m_byte = INIT_TBL[4 - m_init_left]; m_rs = 1'b0;
          m_len = xfer_len(1'b0, m_byte); m_acc = cyc + 1; m_active = 1;
          m_init_left--;
        end else if (m_init_left == 0 && (!m_active || cyc - m_acc >= m_len) && bus.i_wr_vld) begin
          m_byte = bus.i_wr_data; m_rs = bus.i_wr_rs;
          m_len = xfer_len(m_rs, m_byte); m_acc = cyc + 1; m_active = 1;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model, plus EN pulse capture.
  initial begin
    int   d;
    logic e_en, e_rdy, prev_en;
    prev_en = 1'b0;
    forever begin
      @(negedge clk);
      d     = cyc - m_acc;
      e_en  = m_active && (d >= S) && (d < S + E);
      e_rdy = (m_init_left == 0) && !(m_active && d < m_len);
      chk("mon_en",   lcd_en, e_en);
      chk("mon_rdy",  bus.o_wr_rdy, e_rdy);
      chk("mon_busy", bus.o_busy, !e_rdy);
      chk("mon_data", lcd_data, m_byte);
      chk("mon_rs",   lcd_rs, m_rs);
      chk("mon_rw",   lcd_rw, 1'b0);
      chk("mon_on",   lcd_on, m_on);
      if (lcd_en && !prev_en) pulses.push_back(lcd_data);
      prev_en = lcd_en;
    end
  end

  task automatic send(input logic rs, input logic [7:0] d, input bit drop, output int acc);
    int   n;
    logic took;
    n = 0; took = 1'b0;
    bus.i_wr_vld = 1'b1; bus.i_wr_rs = rs; bus.i_wr_data = d;
    while (!took && n < 500) begin
      took = bus.o_wr_rdy;
      @(negedge clk);
      n++;
    end
    chk("accepted", took, 1'b1);
    if (drop) bus.i_wr_vld = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_rdy();
    int n;
    n = 0;
    while (!bus.o_wr_rdy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("rdy_wait", bus.o_wr_rdy, 1'b1);
  endtask

  task automatic wait_en();
    int n;
    n = 0;
    while (!lcd_en && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("en_wait", lcd_en, 1'b1);
  endtask

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         busy;
  } vec_t;

  initial begin
    vec_t vt [9];
    int   acc, acc2, c0, gap;
    logic rs;
    logic [7:0] dat;

    vt[0] = '{1'b1, 8'h41, 18};
    vt[1] = '{1'b0, 8'h01, 48};
    vt[2] = '{1'b1, 8'h01, 18};
    vt[3] = '{1'b0, 8'h02, 48};
    vt[4] = '{1'b0, 8'h03, 48};
    vt[5] = '{1'b0, 8'h04, 18};
    vt[6] = '{1'b0, 8'h00, 18};
    vt[7] = '{1'b1, 8'h02, 18};
    vt[8] = '{1'b0, 8'h80, 18};

    bus.i_wr_vld = 1'b0; bus.i_wr_rs = 1'b0; bus.i_wr_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_rdy",  bus.o_wr_rdy, (INIT_N == 0));
    chk("rst_en",   lcd_en, 1'b0);
    chk("rst_data", lcd_data, 8'h00);
    chk("rst_on",   lcd_on, 1'b0);
    rst = 1'b0;
    c0 = cyc;
    pulses.delete();
    @(negedge clk);
    chk("on_after_release", lcd_on, 1'b1);
`ifdef LCD_INIT_EN
    wait_rdy();
    chk("init_rdy_cycles", cyc - (c0 + 1), 102);
    chk("init_count", pulses.size(), 4);
    for (int i = 0; i < 4 && i < pulses.size(); i++) chk("init_byte", pulses[i], INIT_TBL[i]);
`endif

    // Vector table: busy duration and latched byte per write
    foreach (vt[i]) begin
      send(vt[i].rs, vt[i].data, 1'b1, acc);
      chk("tbl_data", lcd_data, vt[i].data);
      chk("tbl_rs",   lcd_rs, vt[i].rs);
      wait_rdy();
      chk("tbl_busy", cyc - acc, vt[i].busy);
      chk("tbl_keep", lcd_data, vt[i].data);
    end

    // Back-to-back with valid held high: second byte taken on first idle cycle
    pulses.delete();
    send(1'b1, 8'h30, 1'b0, acc);
    send(1'b1, 8'h31, 1'b1, acc2);
    chk("b2b_gap", acc2 - acc, 19);
    wait_rdy();
    chk("b2b_count", pulses.size(), 2);
    if (pulses.size() == 2) begin
      chk("b2b_first",  pulses[0], 8'h30);
      chk("b2b_second", pulses[1], 8'h31);
    end

    // Request during PULSE is dropped
    pulses.delete();
    send(1'b1, 8'hAA, 1'b1, acc);
    wait_en();
    bus.i_wr_vld = 1'b1; bus.i_wr_rs = 1'b1; bus.i_wr_data = 8'h55;
    @(negedge clk);
    bus.i_wr_vld = 1'b0;
    wait_rdy();
    repeat (3) @(negedge clk);
    chk("drop_count", pulses.size(), 1);
    chk("drop_data",  lcd_data, 8'hAA);

    // Asynchronous reset in the middle of the EN pulse
    send(1'b1, 8'h5A, 1'b1, acc);
    wait_en();
    #2 rst = 1'b1;
    #1;
    chk("arst_en",   lcd_en, 1'b0);
    chk("arst_data", lcd_data, 8'h00);
    chk("arst_rs",   lcd_rs, 1'b0);
    chk("arst_rdy",  bus.o_wr_rdy, (INIT_N == 0));
    chk("arst_on",   lcd_on, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wait_rdy();

    // Random writes, command bytes biased toward the long-wait codes
    pulses.delete();
    exp_q.delete();
    for (int k = 0; k < 40; k++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      rs  = 1'($urandom_range(0, 1));
      dat = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
      exp_q.push_back(dat);
      send(rs, dat, 1'b1, acc);
    end
    wait_rdy();
    repeat (2) @(negedge clk);
    chk("rnd_count", pulses.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < pulses.size(); i++) chk("rnd_pulse", pulses[i], exp_q[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule

`default_nettype wire
